// File: rtl/muldiv_seq_if.sv
// Issue/result bundle between the EX stage and the multi-cycle multiply/divide sequencer.
// EX drives the master side; the sequencer is the slave.
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_zero;

  modport master (
    output start, op, a, b, flush,
    input  stall, busy, done, result, div_zero
  );

  modport slave (
    input  start, op, a, b, flush,
    output stall, busy, done, result, div_zero
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative radix-2 shift-add multiplier and restoring divider on operand magnitudes.
// The sign is applied in a single fixup cycle after WIDTH iterations.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t r_state, w_next;

  logic             r_is_div, r_sel_hi, r_sa, r_sb, r_div_zero;
  logic [WIDTH-1:0] r_ma, r_mb, r_hi, r_lo, r_result;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_div, w_is_uns, w_sel_hi, w_sa, w_sb, w_b_zero, w_accept;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_sum, w_rem_sh;
  logic             w_borrow;
  logic [WIDTH-1:0] w_diff, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_stall, w_busy, w_done;

  assign {w_is_div, w_is_uns, w_sel_hi} = bus.op;
  assign w_sa     = bus.a[WIDTH-1] & ~w_is_uns;
  assign w_sb     = bus.b[WIDTH-1] & ~w_is_uns;
  assign w_abs_a  = w_sa ? -bus.a : bus.a;
  assign w_abs_b  = w_sb ? -bus.b : bus.b;
  assign w_b_zero = (bus.b == '0);
  assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;

  // Multiply step: {hi,lo} holds the partial product with the multiplier shifting out of lo.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : '0);

  // Divide step: {hi,lo} holds {remainder, dividend/quotient}.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_borrow = (w_rem_sh < {1'b0, r_mb});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_mb;

  assign w_prod   = (r_sa ^ r_sb) ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_quo    = (r_sa ^ r_sb) ? -r_lo : r_lo;
  assign w_rem    = r_sa ? -r_hi : r_hi;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next  = r_state;
    w_stall = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_stall = w_accept;
        if (w_accept) w_next = (w_is_div & w_b_zero) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        w_stall = 1'b1;
        if (r_cnt == '0) w_next = S_FIXUP;
      end
      S_FIXUP: begin
        w_stall = 1'b1;
        w_next  = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div   <= 1'b0;
      r_sel_hi   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_div_zero <= 1'b0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
    end else if (!bus.flush) begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_is_div   <= w_is_div;
          r_sel_hi   <= w_sel_hi;
          r_sa       <= w_sa;
          r_sb       <= w_sb;
          r_ma       <= w_abs_a;
          r_mb       <= w_abs_b;
          r_hi       <= '0;
          r_lo       <= w_is_div ? w_abs_a : w_abs_b;
          r_cnt      <= CNT_W'(WIDTH - 1);
          r_div_zero <= w_is_div & w_b_zero;
          // Divide by zero skips the datapath; the result is known at accept.
          if (w_is_div & w_b_zero) r_result <= w_sel_hi ? bus.a : '1;
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_is_div) begin
            r_hi <= w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff;
            r_lo <= {r_lo[WIDTH-2:0], ~w_borrow};
          end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        S_FIXUP: begin
          if (r_is_div) r_result <= r_sel_hi ? w_rem : w_quo;
          else          r_result <= r_sel_hi ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.stall    = w_stall;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.result   = r_result;
  assign bus.div_zero = r_div_zero & w_done;
endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a plain-arithmetic reference model.
module tb_muldiv_seq;
  localparam int W = 32;
  localparam logic [2:0] OP_MUL  = 3'b000, OP_MUH  = 3'b001, OP_MULU = 3'b010, OP_MUHU = 3'b011;
  localparam logic [2:0] OP_DIV  = 3'b100, OP_MOD  = 3'b101, OP_DIVU = 3'b110, OP_MODU = 3'b111;

  logic clk = 1'b0;
  logic rst;
  muldiv_seq_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] last_result;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic dz);
    longint          sa_, sb_, p;
    longint unsigned ua, ub, up;
    dz = 1'b0;
    if (!op[2]) begin
      if (op[1]) begin
        ua = a; ub = b; up = ua * ub;
        r = op[0] ? up[63:32] : up[31:0];
      end else begin
        sa_ = $signed(a); sb_ = $signed(b); p = sa_ * sb_;
        r = op[0] ? p[63:32] : p[31:0];
      end
    end else if (b == '0) begin
      dz = 1'b1;
      r  = op[0] ? a : '1;
    end else if (op[1]) begin
      r = op[0] ? a % b : a / b;
    end else begin
      sa_ = $signed(a); sb_ = $signed(b);
      r = op[0] ? 32'(sa_ % sb_) : 32'(sa_ / sb_);
    end
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0:       v = '0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one op in the cycle after the call and follows it to its done pulse.
  // spur_k > 0 raises a second start at that cycle of the op, which must be ignored.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag, input int spur_k);
    logic [W-1:0] exp_r;
    logic         exp_dz;
    int           exp_lat, lat, bad_cycles;
    model(op, a, b, exp_r, exp_dz);
    exp_lat    = (op[2] && b == '0) ? 1 : W + 2;
    lat        = 0;
    bad_cycles = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
      $display("FAIL %s issue: stall=%b busy=%b done=%b div_zero=%b, want 1 0 0 0",
               tag, bus.stall, bus.busy, bus.done, bus.div_zero);
      n_fail++;
    end
    n_checks++;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
      end
      bus.start = (k == spur_k);
      #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1) bad_cycles++;
    end
    bus.start = 1'b0;
    if (lat != exp_lat) begin
      $display("FAIL %s latency: got %0d want %0d (0 = no done within budget)", tag, lat, exp_lat);
      n_fail++;
    end
    n_checks++;
    if (bus.result !== exp_r) begin
      $display("FAIL %s result: got %h want %h (op=%b a=%h b=%h)", tag, bus.result, exp_r, op, a, b);
      n_fail++;
    end
    n_checks++;
    if (bus.div_zero !== exp_dz) begin
      $display("FAIL %s div_zero: got %b want %b", tag, bus.div_zero, exp_dz);
      n_fail++;
    end
    n_checks++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b1) begin
      $display("FAIL %s done-cycle flags: stall=%b busy=%b, want 0 1", tag, bus.stall, bus.busy);
      n_fail++;
    end
    n_checks++;
    if (bad_cycles != 0) begin
      $display("FAIL %s in-flight stall/busy: %0d bad cycles, want 0", tag, bad_cycles);
      n_fail++;
    end
    n_checks++;
    last_result = exp_r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    if ({bus.stall, bus.busy, bus.done, bus.div_zero} !== 4'b0 || bus.result !== '0) begin
      $display("FAIL reset outputs: stall=%b busy=%b done=%b dz=%b result=%h, want all 0",
               bus.stall, bus.busy, bus.done, bus.div_zero, bus.result);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      $display("FAIL post-reset idle: busy=%b stall=%b, want 0 0", bus.busy, bus.stall);
      n_fail++;
    end
    n_checks++;
    last_result = '0;
  endtask

  task automatic test_directed();
    do_op(OP_MUL,  32'hFFFF_FFFD, 32'd5,        "mul_neg3x5", 0);
    do_op(OP_MUH,  32'hFFFF_FFFD, 32'd5,        "muh_neg3x5", 0);
    do_op(OP_MUHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "muhu_max",  0);
    do_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulu_max",  0);
    do_op(OP_MUH,  32'h8000_0000, 32'h8000_0000, "muh_minsq", 0);
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,        "div_neg7_2", 0);
    do_op(OP_MOD,  32'hFFFF_FFF9, 32'd2,        "mod_neg7_2", 0);
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",   0);
    do_op(OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, "mod_ovf",   0);
    do_op(OP_DIVU, 32'h0000_1234, 32'd0,        "divu_zero",  0);
    do_op(OP_MODU, 32'h0000_1234, 32'd0,        "modu_zero",  0);
    do_op(OP_DIV,  32'd100,       32'hFFFF_FFF9, "div_after_z", 0);
    do_op(OP_MOD,  32'd100,       32'hFFFF_FFF9, "mod_neg_div", 0);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1,        "divu_by1",   0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) do_op(OP_MUL, 32'hFFFF_FFFD, 32'd5, "b2b_repeat", 0);
    do_op(OP_DIV, 32'h7FFF_FFFF, 32'd0, "b2b_div_zero", 0);
    do_op(OP_MODU, 32'd77, 32'd10, "b2b_modu", 0);
  endtask

  task automatic test_ignored_start();
    do_op(OP_DIVU, 32'hDEAD_BEEF, 32'd12345, "ignored_start", 5);
    do_op(OP_MUH, 32'h1234_5678, 32'hF000_0001, "ignored_start2", 20);
  endtask

  task automatic test_flush();
    logic [W-1:0] held;
    int           seen;
    held = last_result;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL flush idle: busy=%b stall=%b done=%b, want 0 0 0", bus.busy, bus.stall, bus.done);
      n_fail++;
    end
    n_checks++;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    if (seen != 0) begin
      $display("FAIL flush no-done: got %0d done pulses, want 0", seen);
      n_fail++;
    end
    n_checks++;
    if (bus.result !== held) begin
      $display("FAIL flush result held: got %h want %h", bus.result, held);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_MUL; bus.a = 32'd3; bus.b = 32'd4;
    #1;
    if (bus.stall !== 1'b0) begin
      $display("FAIL flush+start stall: got %b want 0", bus.stall);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    #1;
    if (bus.busy !== 1'b0 || bus.result !== held) begin
      $display("FAIL flush+start dropped: busy=%b result=%h, want 0 %h", bus.busy, bus.result, held);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_rst_midop();
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULU; bus.a = 32'hCAFE_F00D; bus.b = 32'h0BAD_F00D;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    if ({bus.stall, bus.busy, bus.done, bus.div_zero} !== 4'b0 || bus.result !== '0) begin
      $display("FAIL rst mid-op: stall=%b busy=%b done=%b dz=%b result=%h, want all 0",
               bus.stall, bus.busy, bus.done, bus.div_zero, bus.result);
      n_fail++;
    end
    n_checks++;
    last_result = '0;
    do_op(OP_MULU, 32'hCAFE_F00D, 32'h0BAD_F00D, "after_rst", 0);
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      do_op(op, a, b, "random", 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    last_result = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_flush();
    test_rst_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the MUL/MUH/MULU/MUHU/DIV/MOD/DIVU/MODU ALU operations.
- Implements iterative radix-2 shift-add multiply and restoring divide.
- The EX stage issues an op, and the block stalls the pipeline until the result is ready.
- A flush input aborts an in-flight op on an exception or ERET redirect.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  issue request from EX; sampled only in IDLE
op  in  3  {is_div, is_unsigned, sel_hi}: sel_hi picks MUH/MOD over MUL/DIV
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  abort current op; return to IDLE
stall  out  1  hold the pipeline front-end
busy  out  1  state != IDLE
done  out  1  one-cycle pulse; result valid this cycle
result  out  WIDTH  selected half/quotient/remainder, held until next accepted start
div_zero  out  1  set with done when a divide had b == 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- States: IDLE, CALC, FIXUP, DONE.
- Reset: state=IDLE. stall=0, busy=0, done=0, result=0, div_zero=0. All internal registers are cleared.
- rst has priority over flush, and flush has priority over start and over any state transition.

- IDLE, start=1 (accept):
  - Latch op.
  - Latch sign flags: sa=a[MSB]&~is_unsigned and sb=b[MSB]&~is_unsigned.
  - Latch magnitudes |a| and |b|; the 2's-complement magnitude of the most negative value is 2^(WIDTH-1), held unsigned.
  - Counter cnt=WIDTH-1.
  - If is_div and b==0: go to DONE next cycle, result=all-ones for DIV/DIVU or a for MOD/MODU, div_zero=1.
  - Otherwise go to CALC.
- CALC, multiply:
  - 2*WIDTH-bit product register {hi, lo}, with lo initialised to |b|.
  - Each cycle: if lo[0], hi += |a| with carry. Then shift the combined {carry,hi,lo} right by 1.
- CALC, divide:
  - rem starts at 0, quo starts at |a|.
  - Each cycle: shift {rem,quo} left 1 and trial-subtract |b| from rem.
  - If no borrow, rem=diff and quo[0]=1; else quo[0]=0.
- CALC exit: cnt decrements each cycle; when cnt==0, go to FIXUP. CALC lasts exactly WIDTH cycles.
- FIXUP sign correction:
  - Product: negated over 2*WIDTH bits if sa^sb.
  - Quotient: negated if sa^sb.
  - Remainder: negated if sa, so it takes the sign of the dividend.
- FIXUP result select:
  - sel_hi=0: product low half, or quotient.
  - sel_hi=1: product high half, or remainder.
- FIXUP loads result and goes to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. div_zero is valid only while done=1 and is 0 otherwise.
- Latency, normal op: start accepted at cycle 0 gives done at cycle WIDTH+2.
- Latency, divide-by-zero: done at cycle 1.
- stall = (state==IDLE & start) | state==CALC | state==FIXUP. stall is low in DONE so EX can capture result that cycle.
- busy is high in CALC, FIXUP and DONE.
- start while state != IDLE is ignored: no queuing, no effect on the current op.
- Signed overflow, most-negative / -1: quotient = most-negative value, remainder = 0. This falls out of magnitude arithmetic truncated to WIDTH; no trap is raised.
- flush in any state: go to IDLE next cycle; done is not pulsed and result is unchanged.
- flush and start in the same IDLE cycle: start is dropped and stall=0 that cycle.
- start with op and operands identical to the previous op is recomputed in full; there is no result caching.

Test Plan:
- MUL a=0xFFFFFFFD (-3), b=5 -> done at cycle 34, result=0xFFFFFFF1; same operands with MUH -> 0xFFFFFFFF; stall high cycles 0-33, low at 34.
- MULU a=b=0xFFFFFFFF with MUHU -> result=0xFFFFFFFE; with MULU -> 0x00000001.
- DIV a=-7, b=2 -> result=0xFFFFFFFD (-3); MOD -> 0xFFFFFFFF (-1); DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; MOD -> 0.
- DIVU a=0x1234, b=0 -> done at cycle 1, div_zero=1, result=0xFFFFFFFF; MODU -> result=0x1234, div_zero=1; next normal divide -> div_zero=0.
- DIV start, then flush at cycle 10 -> IDLE at cycle 11, no done pulse, result keeps its prior value. A second start at cycle 5 of an op is ignored; the first op completes with its own result.
- rst asserted at cycle 15 of a MULU -> next cycle all outputs at reset values; start the following cycle completes normally in 34 cycles.
